// File: rtl/adc_capture_buf.sv
// ADC capture buffer: registers an offset-binary ADC bus, optionally waits for a
// rising level trigger, stores one frame in block RAM and streams it out over valid/ready.
module adc_capture_buf #(
  parameter int DATA_WIDTH  = 14,
  parameter int SAMPLE_RATE = 0,
  parameter int DEPTH       = 1024,
  parameter int ADDR_WIDTH  = 10
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [DATA_WIDTH-1:0] adc_data_in,
  input  logic                  arm_in,
  input  logic                  trig_en_in,
  input  logic [DATA_WIDTH-1:0] trig_level_in,
  output logic [DATA_WIDTH-1:0] rd_data_out,
  output logic                  rd_valid_out,
  input  logic                  rd_ready_in,
  output logic                  rd_last_out,
  output logic                  busy_out
);

  localparam int CNT_W = (SAMPLE_RATE > 0) ? $clog2(SAMPLE_RATE + 1) : 1;
  localparam logic [CNT_W-1:0]      CNT_MAX   = CNT_W'(SAMPLE_RATE);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_TRIG = 2'd1,
    CAPTURE   = 2'd2,
    READOUT   = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   adc_q;
  logic [CNT_W-1:0]        dec_cnt_q, dec_cnt_d;
  logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
  logic [ADDR_WIDTH-1:0]   rd_addr_q, rd_addr_d;
  logic [DATA_WIDTH-1:0]   prev_q, prev_d;
  logic                    prev_valid_q, prev_valid_d;
  logic                    rd_valid_q, rd_valid_d;
  logic                    rd_last_q, rd_last_d;
  logic                    busy_q;

  logic [DATA_WIDTH-1:0]   sample;
  logic                    strobe;
  logic                    trig_hit;
  logic                    wr_en;
  logic [ADDR_WIDTH-1:0]   wr_sel;
  logic                    rd_en;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic [DATA_WIDTH-1:0]   ram_rd_q;

  // Offset binary to two's complement is just an MSB flip.
  assign sample    = {~adc_q[DATA_WIDTH-1], adc_q[DATA_WIDTH-2:0]};
  assign strobe    = (dec_cnt_q == '0);
  assign dec_cnt_d = (dec_cnt_q == CNT_MAX) ? '0 : dec_cnt_q + CNT_W'(1);
  assign trig_hit  = prev_valid_q
                   && ($signed(prev_q) < $signed(trig_level_in))
                   && ($signed(sample) >= $signed(trig_level_in));

  always_comb begin
    state_d      = state_q;
    wr_addr_d    = wr_addr_q;
    rd_addr_d    = rd_addr_q;
    prev_d       = prev_q;
    prev_valid_d = prev_valid_q;
    rd_valid_d   = rd_valid_q;
    rd_last_d    = rd_last_q;
    wr_en        = 1'b0;
    wr_sel       = wr_addr_q;
    rd_en        = 1'b0;
    unique case (state_q)
      IDLE: begin
        wr_addr_d    = '0;
        rd_addr_d    = '0;
        prev_valid_d = 1'b0;
        if (arm_in) state_d = trig_en_in ? WAIT_TRIG : CAPTURE;
      end
      WAIT_TRIG: begin
        if (strobe) begin
          prev_d       = sample;
          prev_valid_d = 1'b1;
          if (trig_hit) begin
            wr_en     = 1'b1;
            wr_sel    = '0;
            wr_addr_d = ADDR_ONE;
            state_d   = CAPTURE;
          end
        end
      end
      CAPTURE: begin
        if (strobe) begin
          wr_en = 1'b1;
          if (wr_addr_q == ADDR_LAST) begin
            // Prefetch address 0 so the first sample is valid on entry to READOUT.
            state_d    = READOUT;
            rd_addr_d  = '0;
            rd_en      = 1'b1;
            rd_valid_d = 1'b1;
            rd_last_d  = 1'b0;
          end else begin
            wr_addr_d = wr_addr_q + ADDR_ONE;
          end
        end
      end
      READOUT: begin
        if (rd_valid_q && rd_ready_in) begin
          if (rd_last_q) begin
            state_d    = IDLE;
            rd_valid_d = 1'b0;
            rd_last_d  = 1'b0;
          end else begin
            rd_addr_d = rd_addr_q + ADDR_ONE;
            rd_en     = 1'b1;
            rd_last_d = (rd_addr_q == ADDR_LAST - ADDR_ONE);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q      <= IDLE;
      adc_q        <= '0;
      dec_cnt_q    <= '0;
      wr_addr_q    <= '0;
      rd_addr_q    <= '0;
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_last_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      adc_q        <= adc_data_in;
      dec_cnt_q    <= dec_cnt_d;
      wr_addr_q    <= wr_addr_d;
      rd_addr_q    <= rd_addr_d;
      prev_q       <= prev_d;
      prev_valid_q <= prev_valid_d;
      rd_valid_q   <= rd_valid_d;
      rd_last_q    <= rd_last_d;
      busy_q       <= (state_d != IDLE);
    end
  end

  // RAM read register only loads on a fetch, so stalled output data stays put.
  always_ff @(posedge clk_in) begin
    if (wr_en) mem[wr_sel] <= sample;
    if (rd_en) ram_rd_q <= mem[rd_addr_d];
  end

  assign rd_data_out  = rd_valid_q ? ram_rd_q : '0;
  assign rd_valid_out = rd_valid_q;
  assign rd_last_out  = rd_last_q;
  assign busy_out     = busy_q;

endmodule

// File: tb/tb_adc_capture_buf.sv
// Bench for adc_capture_buf: two instances (decimation 0 and 3) share stimulus;
// expected frames come from a sample-stream model and are checked by a readout monitor.
module tb_adc_capture_buf;
  localparam int DW    = 14;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int WLEN  = 8192;

  logic          clk = 1'b1;
  logic          rst_n = 1'b1;
  logic [DW-1:0] adc_data = 14'h2000;
  logic          arm = 1'b0;
  logic          trig_en = 1'b0;
  logic [DW-1:0] trig_level = '0;
  logic [DW-1:0] rd_data [2];
  logic          rd_valid [2];
  logic          rd_last [2];
  logic          busy [2];
  logic          rd_ready [2];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    adc_capture_buf #(
      .DATA_WIDTH (DW),
      .SAMPLE_RATE(gi * 3),
      .DEPTH      (DEPTH),
      .ADDR_WIDTH (AW)
    ) u_dut (
      .clk_in       (clk),
      .rst_in       (rst_n),
      .adc_data_in  (adc_data),
      .arm_in       (arm),
      .trig_en_in   (trig_en),
      .trig_level_in(trig_level),
      .rd_data_out  (rd_data[gi]),
      .rd_valid_out (rd_valid[gi]),
      .rd_ready_in  (rd_ready[gi]),
      .rd_last_out  (rd_last[gi]),
      .busy_out     (busy[gi])
    );
  end

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] wave [WLEN];
  int neg_idx = 0;
  int j0 = 0;
  int rdy_mode = 0;
  logic [DW-1:0] exp0 [$];
  logic [DW-1:0] exp1 [$];
  logic [DW-1:0] tmp_q [$];
  bit hold [2];
  bit hs_prev [2];
  bit after_last [2];
  logic [DW-1:0] pd [2];
  logic pl [2];

  // Input sampled at posedge j is wave[j], driven at the preceding negedge.
  always @(negedge clk) begin
    adc_data = (neg_idx < WLEN) ? wave[neg_idx] : 14'h2000;
    for (int i = 0; i < 2; i++)
      rd_ready[i] = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    neg_idx++;
  end

  task automatic chk(input string name, input int inst, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s inst=%0d actual=%0d required=%0d", name, inst, act, req);
    end
  endtask

  function automatic int to_signed(input logic [DW-1:0] v);
    return int'($signed(v));
  endfunction

  // Sample stream model: strobes every sr+1 edges from reset release; value = code - 8192.
  function automatic bit model(input int sr, input int a, input bit trig, input int lvl);
    int  jj = a + 1;
    bit  found = !trig;
    bit  have_prev = 0;
    int  prev = 0;
    int  s;
    tmp_q.delete();
    while (tmp_q.size() < DEPTH && jj < WLEN) begin
      if (((jj - j0) % (sr + 1)) == 0) begin
        s = int'(wave[jj-1]) - 8192;
        if (found) tmp_q.push_back(DW'(s));
        else begin
          if (have_prev && prev < lvl && s >= lvl) begin
            found = 1;
            tmp_q.push_back(DW'(s));
          end
          prev = s;
          have_prev = 1;
        end
      end
      jj++;
    end
    return tmp_q.size() == DEPTH;
  endfunction

  task automatic mon(input int i);
    logic          v = rd_valid[i];
    logic          r = rd_ready[i];
    logic [DW-1:0] d = rd_data[i];
    logic          l = rd_last[i];
    logic [DW-1:0] e;
    int            rem;
    bit            have;
    if (after_last[i]) begin
      chk("post_last_valid", i, int'(v), 0);
      chk("post_last_busy", i, int'(busy[i]), 0);
      after_last[i] = 0;
    end
    if (hold[i]) begin
      chk("hold_valid", i, int'(v), 1);
      chk("hold_data", i, to_signed(d), to_signed(pd[i]));
      chk("hold_last", i, int'(l), int'(pl[i]));
    end
    if (hs_prev[i]) chk("no_bubble", i, int'(v), 1);
    hs_prev[i] = 0;
    if (v && r) begin
      have = (i == 0) ? (exp0.size() > 0) : (exp1.size() > 0);
      if (!have) begin
        checks++;
        errors++;
        $display("FAIL extra_sample inst=%0d actual=%0d required=none", i, to_signed(d));
      end else begin
        if (i == 0) begin e = exp0.pop_front(); rem = exp0.size(); end
        else begin e = exp1.pop_front(); rem = exp1.size(); end
        chk("data", i, to_signed(d), to_signed(e));
        chk("last", i, int'(l), int'(rem == 0));
        $display("inst=%0d sample=%0d last=%0d remaining=%0d", i, to_signed(d), l, rem);
        if (rem == 0) after_last[i] = 1;
        else hs_prev[i] = 1;
      end
    end
    hold[i] = v && !r;
    pd[i] = d;
    pl[i] = l;
  endtask

  always @(negedge clk) begin
    #1;
    if (rst_n) for (int i = 0; i < 2; i++) mon(i);
  end

  task automatic wait_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic fill(input int kind, input int start);
    for (int k = start; k < WLEN && k < start + 1500; k++) begin
      case (kind)
        0:       wave[k] = DW'(8192 + (k - start));
        1:       wave[k] = DW'(8192 + int'(3000.0 * $sin(6.2831853 * real'(k - start) / 29.0)));
        default: wave[k] = DW'($urandom);
      endcase
    end
  endtask

  task automatic clear_mon();
    exp0.delete();
    exp1.delete();
    for (int i = 0; i < 2; i++) begin
      hold[i] = 0;
      hs_prev[i] = 0;
      after_last[i] = 0;
    end
  endtask

  task automatic run_frame(input int kind, input bit trig, input int lvl, input int mode,
                           input bit noise);
    int a;
    int cnt;
    wait_neg();
    fill(kind, neg_idx);
    repeat (3) wait_neg();
    trig_en = trig;
    trig_level = DW'(lvl);
    rdy_mode = mode;
    chk("idle_busy", 0, int'(busy[0]), 0);
    chk("idle_busy", 1, int'(busy[1]), 0);
    a = neg_idx - 1;
    arm = 1'b1;
    for (int i = 0; i < 2; i++) begin
      if (!model(i * 3, a, trig, lvl)) begin
        checks++;
        errors++;
        $display("FAIL model_frame inst=%0d actual=%0d required=%0d", i, tmp_q.size(), DEPTH);
      end else if (i == 0) exp0 = tmp_q;
      else exp1 = tmp_q;
    end
    wait_neg();
    arm = 1'b0;
    cnt = 0;
    while ((exp0.size() != 0 || exp1.size() != 0 || busy[0] || busy[1]) && cnt < 3000) begin
      wait_neg();
      arm = (noise && busy[0] && busy[1] && $urandom_range(0, 3) == 0);
      cnt++;
    end
    arm = 1'b0;
    chk("frame_done_in_time", 0, int'(cnt < 3000), 1);
    if (cnt >= 3000) clear_mon();
  endtask

  task automatic check_reset_outputs();
    for (int i = 0; i < 2; i++) begin
      chk("rst_valid", i, int'(rd_valid[i]), 0);
      chk("rst_last", i, int'(rd_last[i]), 0);
      chk("rst_data", i, int'(rd_data[i]), 0);
      chk("rst_busy", i, int'(busy[i]), 0);
    end
  endtask

  initial begin
    for (int k = 0; k < WLEN; k++) wave[k] = 14'h2000;
    rd_ready[0] = 1'b1;
    rd_ready[1] = 1'b1;
    #1 rst_n = 1'b0;
    #2 check_reset_outputs();
    repeat (2) wait_neg();
    rst_n = 1'b1;
    j0 = neg_idx - 1;

    run_frame(0, 1'b0, 0, 0, 1'b0);
    run_frame(1, 1'b1, 100, 0, 1'b0);
    run_frame(2, 1'b0, 0, 1, 1'b1);
    run_frame(1, 1'b1, -500, 1, 1'b1);

    // Abandon a capture with reset, then take a fresh frame.
    wait_neg();
    fill(2, neg_idx);
    repeat (3) wait_neg();
    trig_en = 1'b0;
    arm = 1'b1;
    wait_neg();
    arm = 1'b0;
    repeat (5) wait_neg();
    chk("busy_before_reset", 0, int'(busy[0]), 1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs();
    clear_mon();
    repeat (2) wait_neg();
    rst_n = 1'b1;
    j0 = neg_idx - 1;
    run_frame(0, 1'b0, 0, 1, 1'b0);

    for (int n = 0; n < 4; n++)
      run_frame(1, 1'b1, $urandom_range(0, 4000) - 2000, 1, 1'b1);
    run_frame(2, 1'b0, 0, 0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end
endmodule
